// File: rtl/encounter_controller.sv
// Game-flow controller: random wild encounters from grass steps, battle transition
// handshake, battle outcome bookkeeping (XP, level, evolution) and global game state.
module encounter_controller #(
  parameter logic [7:0] ENCOUNTER_THRESH = 8'd25,
  parameter logic [7:0] MIN_STEPS        = 8'd3,
  parameter logic [7:0] START_LEVEL      = 8'd5,
  parameter logic [7:0] XP_STEP          = 8'd10,
  parameter logic [7:0] EVOLVE_LEVEL     = 8'd16,
  parameter logic [7:0] EVOLVE_STEP      = 8'd20,
  parameter logic [7:0] EVOLVE_FRAMES    = 8'd120,
  parameter logic [7:0] TRANS_TIMEOUT    = 8'd60,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        step_in,
  input  logic        in_grass_in,
  input  logic        trans_done_in,
  input  logic        battle_won_in,
  input  logic        battle_lost_in,
  input  logic [7:0]  xp_gain_in,
  output logic [2:0]  state_out,
  output logic        trans_start_out,
  output logic [7:0]  level_out,
  output logic [7:0]  xp_out,
  output logic        evolve_out
);

  localparam logic [2:0] ST_OVERWORLD  = 3'b001;
  localparam logic [2:0] ST_TRANSITION = 3'b010;
  localparam logic [2:0] ST_BATTLE     = 3'b100;
  localparam logic [2:0] ST_EVOLVE     = 3'b011;
  localparam logic [7:0] MAX_LEVEL     = 8'd100;

  logic [2:0] state_reg, state_next;
  logic [7:0] lfsr_reg, lfsr_next;
  logic       pix00_prev_reg;
  logic       tick_reg;
  logic [7:0] steps_reg, steps_next;
  logic [7:0] wd_reg, wd_next;
  logic [7:0] evo_cnt_reg, evo_cnt_next;
  logic [7:0] xp_reg, xp_next;
  logic [7:0] level_reg, level_next;
  logic [7:0] xp_req_reg, xp_req_next;
  logic [7:0] level_evolve_reg, level_evolve_next;
  logic       trans_start_reg, trans_start_next;
  logic       evolve_reg, evolve_next;

  logic       pix00;
  logic [7:0] steps_inc;
  logic [8:0] xp_sum;
  logic [7:0] xp_won;
  logic       level_up;
  logic [7:0] level_inc;
  logic [7:0] level_won;
  logic [8:0] xp_req_sum;
  logic [8:0] level_evolve_sum;
  logic [7:0] wd_inc;
  logic [7:0] evo_cnt_inc;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate

  assign pix00            = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign steps_inc        = (steps_reg == 8'hFF) ? 8'hFF : steps_reg + 8'd1;
  assign xp_sum           = {1'b0, xp_reg} + {1'b0, xp_gain_in};
  assign xp_won           = xp_sum[8] ? 8'hFF : xp_sum[7:0];
  assign level_up         = (xp_won >= xp_req_reg);
  assign level_inc        = (level_reg >= MAX_LEVEL) ? MAX_LEVEL : level_reg + 8'd1;
  assign level_won        = level_up ? level_inc : level_reg;
  assign xp_req_sum       = {1'b0, xp_req_reg} + {1'b0, XP_STEP};
  assign level_evolve_sum = {1'b0, level_evolve_reg} + {1'b0, EVOLVE_STEP};
  assign wd_inc           = wd_reg + 8'd1;
  assign evo_cnt_inc      = evo_cnt_reg + 8'd1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg        <= ST_OVERWORLD;
      lfsr_reg         <= LFSR_SEED;
      pix00_prev_reg   <= 1'b0;
      tick_reg         <= 1'b0;
      steps_reg        <= 8'd0;
      wd_reg           <= 8'd0;
      evo_cnt_reg      <= 8'd0;
      xp_reg           <= 8'd0;
      level_reg        <= START_LEVEL;
      xp_req_reg       <= XP_STEP;
      level_evolve_reg <= EVOLVE_LEVEL;
      trans_start_reg  <= 1'b0;
      evolve_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      lfsr_reg         <= lfsr_next;
      pix00_prev_reg   <= pix00;
      tick_reg         <= pix00 & ~pix00_prev_reg;
      steps_reg        <= steps_next;
      wd_reg           <= wd_next;
      evo_cnt_reg      <= evo_cnt_next;
      xp_reg           <= xp_next;
      level_reg        <= level_next;
      xp_req_reg       <= xp_req_next;
      level_evolve_reg <= level_evolve_next;
      trans_start_reg  <= trans_start_next;
      evolve_reg       <= evolve_next;
    end
  end

  // Next state together with the bookkeeping that changes on the same edge
  always_comb begin
    state_next        = state_reg;
    steps_next        = steps_reg;
    wd_next           = wd_reg;
    evo_cnt_next      = evo_cnt_reg;
    xp_next           = xp_reg;
    level_next        = level_reg;
    xp_req_next       = xp_req_reg;
    level_evolve_next = level_evolve_reg;
    case (state_reg)
      ST_OVERWORLD: begin
        if (step_in && in_grass_in) begin
          steps_next = steps_inc;
          if ((steps_inc >= MIN_STEPS) && (lfsr_reg < ENCOUNTER_THRESH)) begin
            state_next = ST_TRANSITION;
            steps_next = 8'd0;
            wd_next    = 8'd0;
          end
        end
      end
      ST_TRANSITION: begin
        if (tick_reg) begin
          wd_next = wd_inc;
        end
        if (trans_done_in || (tick_reg && (wd_inc >= TRANS_TIMEOUT))) begin
          state_next = ST_BATTLE;
        end
      end
      ST_BATTLE: begin
        if (battle_won_in) begin
          xp_next = xp_won;
          if (level_up) begin
            level_next  = level_inc;
            xp_req_next = xp_req_sum[8] ? 8'hFF : xp_req_sum[7:0];
          end
          if (level_won >= level_evolve_reg) begin
            state_next        = ST_EVOLVE;
            level_evolve_next = level_evolve_sum[8] ? 8'hFF : level_evolve_sum[7:0];
            evo_cnt_next      = 8'd0;
          end else begin
            state_next = ST_OVERWORLD;
          end
        end else if (battle_lost_in) begin
          state_next = ST_OVERWORLD;
        end
      end
      ST_EVOLVE: begin
        if (tick_reg) begin
          evo_cnt_next = evo_cnt_inc;
          if (evo_cnt_inc >= EVOLVE_FRAMES) begin
            state_next = ST_OVERWORLD;
          end
        end
      end
      default: state_next = ST_OVERWORLD;
    endcase
  end

  // Decoded outputs follow the next state so they register alongside it
  always_comb begin
    trans_start_next = (state_next == ST_TRANSITION);
    evolve_next      = (state_next == ST_EVOLVE);
  end

  assign state_out       = state_reg;
  assign trans_start_out = trans_start_reg;
  assign evolve_out      = evolve_reg;
  assign level_out       = level_reg;
  assign xp_out          = xp_reg;

endmodule

// File: tb/tb_encounter_controller.sv
// Directed bench for encounter_controller: encounter gating, transition exit,
// XP/level bookkeeping, evolution timing, win/loss priority and async reset.
module tb_encounter_controller;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        step_in;
  logic        in_grass_in;
  logic        trans_done_in;
  logic        battle_won_in;
  logic        battle_lost_in;
  logic [7:0]  xp_gain_in;
  logic [2:0]  state_out;
  logic        trans_start_out;
  logic [7:0]  level_out;
  logic [7:0]  xp_out;
  logic        evolve_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference LFSR (x^8+x^6+x^5+x^4+1) used to time steps on an encounter-eligible value
  logic [7:0] lfsr_m;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) lfsr_m <= 8'hA5;
    else         lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
  end

  encounter_controller dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .step_in         (step_in),
    .in_grass_in     (in_grass_in),
    .trans_done_in   (trans_done_in),
    .battle_won_in   (battle_won_in),
    .battle_lost_in  (battle_lost_in),
    .xp_gain_in      (xp_gain_in),
    .state_out       (state_out),
    .trans_start_out (trans_start_out),
    .level_out       (level_out),
    .xp_out          (xp_out),
    .evolve_out      (evolve_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0d", tag, got);
    end else begin
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic step_on_hit(input logic grass);
    int waited = 0;
    @(negedge clk_in);
    while ((lfsr_m >= 8'd25) && (waited < 600)) begin
      @(negedge clk_in);
      waited++;
    end
    if (waited >= 600) check_eq("lfsr_wait", waited, 0);
    step_in     = 1'b1;
    in_grass_in = grass;
    @(negedge clk_in);
    step_in     = 1'b0;
    in_grass_in = 1'b0;
  endtask

  task automatic frame_tick();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    @(negedge clk_in);
    hcount_in = 11'd100;
    vcount_in = 10'd50;
    @(negedge clk_in);
  endtask

  task automatic encounter();
    step_on_hit(1'b1);
    step_on_hit(1'b1);
    step_on_hit(1'b1);
    check_eq("enc_state", state_out, 3'b010);
  endtask

  task automatic to_battle();
    trans_done_in = 1'b1;
    @(negedge clk_in);
    trans_done_in = 1'b0;
    check_eq("battle_state", state_out, 3'b100);
  endtask

  task automatic battle_end(input logic won, input logic lost, input logic [7:0] gain);
    battle_won_in  = won;
    battle_lost_in = lost;
    xp_gain_in     = gain;
    @(negedge clk_in);
    battle_won_in  = 1'b0;
    battle_lost_in = 1'b0;
    xp_gain_in     = 8'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_in = 1'b0; step_in = 1'b0; in_grass_in = 1'b0; trans_done_in = 1'b0;
    battle_won_in = 1'b0; battle_lost_in = 1'b0; xp_gain_in = 8'd0;
    hcount_in = 11'd100; vcount_in = 10'd50;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    check_eq("rst_state", state_out, 3'b001);
    check_eq("rst_trans_start", trans_start_out, 1'b0);
    check_eq("rst_evolve", evolve_out, 1'b0);
    check_eq("rst_level", level_out, 8'd5);
    check_eq("rst_xp", xp_out, 8'd0);

    // Two grass steps are not enough; a non-grass step does not count
    step_on_hit(1'b1);
    step_on_hit(1'b1);
    check_eq("two_steps_state", state_out, 3'b001);
    step_on_hit(1'b0);
    check_eq("nongrass_state", state_out, 3'b001);
    step_on_hit(1'b1);
    check_eq("third_step_state", state_out, 3'b010);
    check_eq("third_step_start", trans_start_out, 1'b1);

    to_battle();
    check_eq("battle_start_low", trans_start_out, 1'b0);

    battle_end(1'b1, 1'b0, 8'd12);
    check_eq("win12_xp", xp_out, 8'd12);
    check_eq("win12_level", level_out, 8'd6);
    check_eq("win12_state", state_out, 3'b001);

    // Win and done outside their states are ignored
    battle_end(1'b1, 1'b0, 8'd50);
    check_eq("ign_win_xp", xp_out, 8'd12);
    trans_done_in = 1'b1;
    @(negedge clk_in);
    trans_done_in = 1'b0;
    check_eq("ign_done_state", state_out, 3'b001);

    // Watchdog exit
    encounter();
    repeat (59) frame_tick();
    check_eq("wd59_state", state_out, 3'b010);
    frame_tick();
    check_eq("wd60_state", state_out, 3'b100);

    // Won and lost together: won wins
    battle_end(1'b1, 1'b1, 8'd5);
    check_eq("prio_xp", xp_out, 8'd17);
    check_eq("prio_level", level_out, 8'd6);
    check_eq("prio_state", state_out, 3'b001);

    encounter();
    to_battle();
    battle_end(1'b0, 1'b1, 8'd40);
    check_eq("loss_xp", xp_out, 8'd17);
    check_eq("loss_level", level_out, 8'd6);
    check_eq("loss_state", state_out, 3'b001);

    encounter();
    to_battle();
    battle_end(1'b1, 1'b0, 8'd250);
    check_eq("sat_xp", xp_out, 8'd255);
    check_eq("sat_level", level_out, 8'd7);
    check_eq("sat_state", state_out, 3'b001);

    for (int lvl = 8; lvl <= 15; lvl++) begin
      encounter();
      to_battle();
      battle_end(1'b1, 1'b0, 8'd1);
      check_eq("lvl_up_level", level_out, lvl);
      check_eq("lvl_up_state", state_out, 3'b001);
    end

    encounter();
    to_battle();
    battle_end(1'b1, 1'b0, 8'd1);
    check_eq("evo1_level", level_out, 8'd16);
    check_eq("evo1_state", state_out, 3'b011);
    check_eq("evo1_flag", evolve_out, 1'b1);
    repeat (119) frame_tick();
    check_eq("evo119_state", state_out, 3'b011);
    check_eq("evo119_flag", evolve_out, 1'b1);
    frame_tick();
    check_eq("evo120_state", state_out, 3'b001);
    check_eq("evo120_flag", evolve_out, 1'b0);

    for (int lvl = 17; lvl <= 35; lvl++) begin
      encounter();
      to_battle();
      battle_end(1'b1, 1'b0, 8'd1);
      check_eq("lvl_up_level", level_out, lvl);
      check_eq("lvl_up_state", state_out, 3'b001);
    end

    encounter();
    to_battle();
    battle_end(1'b1, 1'b0, 8'd1);
    check_eq("evo2_level", level_out, 8'd36);
    check_eq("evo2_state", state_out, 3'b011);
    repeat (120) frame_tick();
    check_eq("evo2_exit_state", state_out, 3'b001);

    // Asynchronous reset in the middle of a transition
    encounter();
    #2 rst_in = 1'b0;
    #1;
    check_eq("arst_state", state_out, 3'b001);
    check_eq("arst_level", level_out, 8'd5);
    check_eq("arst_xp", xp_out, 8'd0);
    check_eq("arst_trans_start", trans_start_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check_eq("post_rst_state", state_out, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
